serial_subtractor_8bit: RTL and testbench
=========================================

SERIAL_SUBTRACTOR_8BIT -- requirements
Module: serial_subtractor_8bit

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand and result width in bits.
REQ-002 SHALL have one clock and an asynchronous, active-high reset.
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operands are presented.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts operands.
REQ-007 SHALL have port a, input, WIDTH bits: minuend.
REQ-008 SHALL have port b, input, WIDTH bits: subtrahend.
REQ-009 SHALL have port bin, input, 1 bit: borrow in.
REQ-010 SHALL have port out_valid, output, 1 bit: result is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-012 SHALL have port diff, output, WIDTH bits: difference.
REQ-013 SHALL have port bout, output, 1 bit: borrow out.
REQ-014 SHALL have port busy, output, 1 bit: an operation is in progress (state RUN or DONE).

Function
REQ-015 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-016 SHALL drive in_ready=1 only in IDLE, decoded combinationally from the state.
REQ-017 SHALL accept operands when in_valid&&in_ready at a clock edge: latch a, b and bin into shift registers, clear the bit counter and go to RUN.
REQ-018 SHALL, in RUN, compute one bit per cycle, LSB first, through the full_subtractor, using the stored borrow, then shift the operands right and the result in from the MSB.
REQ-019 SHALL enter DONE at the WIDTH-th RUN edge, so out_valid is first high WIDTH edges after the accepting edge.
REQ-020 SHALL hold diff and bout stable and out_valid=1 in DONE until out_ready=1 at an edge, then go to IDLE.
REQ-021 SHALL keep out_valid=0 in IDLE and RUN; a new accept is possible no earlier than the cycle after leaving DONE.
REQ-022 SHALL ignore in_valid, a, b and bin outside IDLE.
REQ-023 SHALL produce diff = (a - b - bin) mod 2^WIDTH and bout=1 exactly when unsigned a < b + bin.
REQ-024 SHALL ignore out_ready outside DONE.

Reset
REQ-025 SHALL, while rst=1, force state IDLE, out_valid=0, diff=0, bout=0, busy=0, in_ready=1, counter=0 and clear the operand registers.
REQ-026 SHALL, on a reset in RUN or DONE, abort the operation with no out_valid pulse; the first operation after reset is fully correct.

Configuration
REQ-027 SHALL, when macro SUB_OVERFLOW_FLAG_EN is defined, add output port ovf (1 bit), registered alongside diff, equal to 1 when a[MSB]!=b[MSB] and diff[MSB]!=a[MSB] (two's-complement overflow), reset to 0.
REQ-028 SHALL, without SUB_OVERFLOW_FLAG_EN, have no ovf port and no overflow logic.

Structure
REQ-029 SHALL take the FSM state typedef (IDLE/RUN/DONE encoding) and the counter-width localparam ($clog2(WIDTH+1)) from shared package subtractor_pkg.
REQ-030 SHALL instantiate exactly one combinational sub-module, full_subtractor (ports a, b, bin, d, bout: d=a^b^bin, bout=(~a&b)|(~a&bin)|(b&bin)).

Verification
REQ-031 a=0x5A, b=0x23, bin=0 -> diff=0x37, bout=0; out_valid high exactly 8 edges after accept.
REQ-032 a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1 (wrap-around).
REQ-033 a=0xFF, b=0xFF, bin=1 -> diff=0xFF, bout=1; a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0.
REQ-034 With SUB_OVERFLOW_FLAG_EN: a=0x80, b=0x01 -> diff=0x7F, ovf=1; a=0x05, b=0x03 -> ovf=0.
REQ-035 Backpressure: out_ready=0 for 5 cycles in DONE, in_valid pulsed with new operands -> diff, bout and out_valid stable, in_ready=0, new operands ignored; after out_ready=1, IDLE, then in_ready=1.
REQ-036 rst pulsed after 4 RUN cycles -> out_valid never asserted, in_ready=1; next op a=0x09, b=0x04 -> diff=0x05, bout=0.

Source files
------------

// File: rtl/subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the helper that sizes the bit counter.
package subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_e;

  // The counter must hold the values 0..WIDTH.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  localparam int unsigned SUB_WIDTH = 8;
  localparam int unsigned CNT_W     = cnt_width(SUB_WIDTH);

endpackage : subtractor_pkg

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first,
// valid/ready handshake on both sides. Define SUB_OVERFLOW_FLAG_EN to add the ovf output.
module serial_subtractor_8bit
  import subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
`ifdef SUB_OVERFLOW_FLAG_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int unsigned CW = cnt_width(WIDTH);

  sub_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fs_d;
  logic             fs_bout;
  logic             last_bit;

`ifdef SUB_OVERFLOW_FLAG_EN
  logic             ovf_q, ovf_d;
`endif

  full_subtractor u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (borrow_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    cnt_d    = cnt_q;
`ifdef SUB_OVERFLOW_FLAG_EN
    ovf_d    = ovf_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        // Operands drain LSB first; result bits enter at the MSB so that
        // after WIDTH shifts the first computed bit sits at diff[0].
        a_d      = {1'b0, a_q[WIDTH-1:1]};
        b_d      = {1'b0, b_q[WIDTH-1:1]};
        diff_d   = {fs_d, diff_q[WIDTH-1:1]};
        borrow_d = fs_bout;
        cnt_d    = cnt_q + CW'(1);
        if (last_bit) begin
          bout_d  = fs_bout;
`ifdef SUB_OVERFLOW_FLAG_EN
          // a_q[0]/b_q[0] are the original sign bits; fs_d is the result sign.
          ovf_d   = (a_q[0] != b_q[0]) && (fs_d != a_q[0]);
`endif
          state_d = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  // NOTE: the operand shift registers are plain flops, not a memory, so they
  // are cleared on reset along with the rest of the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef SUB_OVERFLOW_FLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign diff      = diff_q;
  assign bout      = bout_q;

endmodule : serial_subtractor_8bit

// File: tb/tb_serial_subtractor_8bit.sv
// Self-checking bench for serial_subtractor_8bit: table-driven operations
// plus backpressure and mid-operation reset sequences.
module tb_serial_subtractor_8bit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         busy;
`ifdef SUB_OVERFLOW_FLAG_EN
  logic         ovf;
`endif

  int checks   = 0;
  int failures = 0;

  serial_subtractor_8bit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
`ifdef SUB_OVERFLOW_FLAG_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] exp_diff;
    logic         exp_bout;
    logic         exp_ovf;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one operation, checks latency and result, then drains it.
  task automatic run_op(input vec_t v, input string tag);
    int lat;
    int wait_cnt;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 20) begin
      tick();
      wait_cnt++;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = v.a; b = v.b; bin = v.bin; in_valid = 1'b1;
    tick();
    // Garbage on the inputs during RUN must not disturb the result.
    a = ~v.a; b = ~v.b; bin = ~v.bin;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (out_valid) break;
      tick();
      lat = k;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(W));
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_diff"}, 32'(diff), 32'(v.exp_diff));
    check({tag, "_bout"}, 32'(bout), 32'(v.exp_bout));
`ifdef SUB_OVERFLOW_FLAG_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(v.exp_ovf));
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_drain_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    vec_t bp;
    vec_t post;
    int   seen;

    //            a      b      bin   diff   bout  ovf
    vecs[0]  = '{8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0};
    vecs[1]  = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3]  = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[5]  = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[6]  = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[7]  = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[8]  = '{8'h01, 8'hFF, 1'b0, 8'h02, 1'b1, 1'b0};
    vecs[9]  = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[10] = '{8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = 8'hA5; b = 8'h3C; bin = 1'b1;
    tick(); tick();
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff",      32'(diff),      32'd0);
    check("rst_bout",      32'(bout),      32'd0);
    check("rst_busy",      32'(busy),      32'd0);
`ifdef SUB_OVERFLOW_FLAG_EN
    check("rst_ovf",       32'(ovf),       32'd0);
`endif
    rst = 1'b0;
    tick();

    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: result held for 5 cycles while new operands are offered.
    bp = vecs[0];
    a = bp.a; b = bp.b; bin = bp.bin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && !out_valid; k++) tick();
    check("bp_valid", 32'(out_valid), 32'd1);
    a = 8'h11; b = 8'h22; bin = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_diff",  32'(diff),      32'h37);
      check("bp_hold_bout",  32'(bout),      32'd0);
      check("bp_hold_ready", 32'(in_ready),  32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready),  32'd1);
    check("bp_release_busy",  32'(busy),      32'd0);

    // Reset during RUN aborts silently; next operation is correct.
    a = 8'hAA; b = 8'h55; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (out_valid) seen++;
    end
    rst = 1'b1;
    #1;
    check("abort_in_ready",  32'(in_ready),  32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy",      32'(busy),      32'd0);
    check("abort_diff",      32'(diff),      32'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (out_valid) seen++;
    end
    check("abort_no_valid", 32'(seen), 32'd0);
    post = vecs[10];
    run_op(post, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serial_subtractor_8bit
